mem_access_unit: RTL and testbench

//  Memory-side stage downstream of the multicycle main-decoder FSM. Turns the
//  per-state strobes irwrite/lord/memwrite/lb into one request on a

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-side access stage: turns controller strobes into one req/ready memory transaction
// and holds the instruction and data registers. Optional abort watchdog: define MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          irwrite,
  input  logic          lord,
  input  logic          memwrite,
  input  logic          lb,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wd,
  output logic          stall,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_READ  = 2'd1,
    KIND_WRITE = 2'd2
  } kind_t;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic          lb_q, lb_d;
  logic [1:0]    off_q, off_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] data_q, data_d;

  logic          req_any;
  kind_t         req_kind;
  logic [7:0]    rd_byte;
  logic [DW-1:0] read_value;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // A write outranks a data read, which outranks an instruction fetch.
  always_comb begin
    req_any = irwrite | lord | memwrite;
    if (memwrite) begin
      req_kind = KIND_WRITE;
    end else if (lord) begin
      req_kind = KIND_READ;
    end else begin
      req_kind = KIND_FETCH;
    end
  end

  // Big-endian byte lanes: offset 0 is the most significant byte of the word.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = mem_rdata[31:24];
      2'd1:    rd_byte = mem_rdata[23:16];
      2'd2:    rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
    read_value = lb_q ? {{(DW-8){rd_byte[7]}}, rd_byte} : mem_rdata;
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    lb_d        = lb_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    instr_d     = instr_q;
    data_d      = data_q;
    stall       = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_any) begin
          stall       = 1'b1;
          kind_d      = req_kind;
          lb_d        = lb;
          off_d       = adr[1:0];
          mem_addr_d  = {adr[AW-1:2], 2'b00};
          mem_wdata_d = wd;
          mem_req_d   = 1'b1;
          mem_we_d    = (req_kind == KIND_WRITE);
          state_d     = BUSY;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end

      BUSY: begin
        stall = 1'b1;
        if (mem_ready) begin
          case (kind_q)
            KIND_FETCH: instr_d = mem_rdata;
            KIND_READ:  data_d  = read_value;
            default: begin
            end
          endcase
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        // Abort lets the controller resume; the stale registers are left untouched.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = CW'(TIMEOUT_CYCLES);
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kind_q      <= KIND_FETCH;
      lb_q        <= 1'b0;
      off_q       <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      data_q      <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      lb_q        <= lb_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      data_q      <= data_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign instr     = instr_q;
  assign data      = data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, randomized accesses
// against a transaction-level model, and hand sequences for reset and watchdog behaviour.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        reset;
  logic        irwrite, lord, memwrite, lb;
  logic [31:0] adr, wd;
  logic        stall;
  logic [31:0] instr, data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        timeout;

  int total;
  int bad;

  logic [31:0] cur_instr;
  logic [31:0] cur_data;
  logic        cur_timeout;

  typedef struct {
    logic        irwrite;
    logic        lord;
    logic        memwrite;
    logic        lb;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_instr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  mem_access_unit #(
    .AW(32),
    .DW(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irwrite(irwrite),
    .lord(lord),
    .memwrite(memwrite),
    .lb(lb),
    .adr(adr),
    .wd(wd),
    .stall(stall),
    .instr(instr),
    .data(data),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Transaction-level reference: what one access must leave behind, from the access rules alone.
  function automatic vec_t makeRandomVec();
    vec_t       v;
    int         off;
    logic [7:0] b;
    v.irwrite  = 1'($urandom_range(0, 1));
    v.lord     = 1'($urandom_range(0, 1));
    v.memwrite = 1'($urandom_range(0, 1));
    v.lb       = 1'($urandom_range(0, 1));
    v.adr      = $urandom;
    v.wd       = $urandom;
    v.rdata    = $urandom;
    v.waits    = int'($urandom_range(0, 3));
    v.exp_addr  = v.adr & 32'hFFFF_FFFC;
    v.exp_we    = v.memwrite;
    v.exp_instr = cur_instr;
    v.exp_data  = cur_data;
    if (v.memwrite) begin
      v.exp_we = 1'b1;
    end else if (v.lord) begin
      if (v.lb) begin
        off = int'(v.adr % 4);
        b = 8'((v.rdata >> (8 * (3 - off))) & 32'hFF);
        v.exp_data = 32'($signed(b));
      end else begin
        v.exp_data = v.rdata;
      end
    end else if (v.irwrite) begin
      v.exp_instr = v.rdata;
    end
    return v;
  endfunction

  task automatic sampleCommon(input string tag);
    checkOutput({tag, "_instr"}, instr, cur_instr);
    checkOutput({tag, "_data"}, data, cur_data);
    checkOutput({tag, "_timeout"}, 32'(timeout), 32'(cur_timeout));
  endtask

  // One complete access: request cycle, BUSY cycles with garbage on ignored inputs, DONE cycle.
  task automatic applyStimulus(input vec_t v);
    logic any_req;
    any_req = v.irwrite | v.lord | v.memwrite;
    @(negedge clk);
    irwrite   = v.irwrite;
    lord      = v.lord;
    memwrite  = v.memwrite;
    lb        = v.lb;
    adr       = v.adr;
    wd        = v.wd;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    checkOutput("idle_stall", 32'(stall), 32'(any_req));
    checkOutput("idle_req", 32'(mem_req), 32'd0);
    sampleCommon("idle");
    if (!any_req) return;
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge clk);
      irwrite   = 1'($urandom_range(0, 1));
      lord      = 1'($urandom_range(0, 1));
      memwrite  = 1'($urandom_range(0, 1));
      lb        = 1'($urandom_range(0, 1));
      adr       = $urandom;
      wd        = $urandom;
      mem_ready = (i == v.waits);
      mem_rdata = (i == v.waits) ? v.rdata : $urandom;
      #1;
      checkOutput("busy_stall", 32'(stall), 32'd1);
      checkOutput("busy_req", 32'(mem_req), 32'd1);
      checkOutput("busy_we", 32'(mem_we), 32'(v.exp_we));
      checkOutput("busy_addr", mem_addr, v.exp_addr);
      checkOutput("busy_wdata", mem_wdata, v.wd);
      sampleCommon("busy");
    end
    @(negedge clk);
    irwrite   = 1'b1;
    lord      = 1'b0;
    memwrite  = 1'b0;
    lb        = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    #1;
    cur_instr = v.exp_instr;
    cur_data  = v.exp_data;
    checkOutput("done_stall", 32'(stall), 32'd0);
    checkOutput("done_req", 32'(mem_req), 32'd0);
    checkOutput("done_we", 32'(mem_we), 32'd0);
    sampleCommon("done");
  endtask

  task automatic clearInputs();
    irwrite   = 1'b0;
    lord      = 1'b0;
    memwrite  = 1'b0;
    lb        = 1'b0;
    adr       = 32'h0;
    wd        = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    cur_instr = 32'h0;
    cur_data = 32'h0;
    cur_timeout = 1'b0;
    clearInputs();
    reset = 1'b1;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0050, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h8C22_0004, 0, 32'h0000_0004, 1'b0, 32'h8C22_0004, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, 2, 32'h0000_0010, 1'b0, 32'h8C22_0004, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0101, 32'h0, 32'h12F4_5678, 0, 32'h0000_0100, 1'b0, 32'h8C22_0004, 32'hFFFF_FFF4};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103, 32'h0, 32'h12F4_5678, 1, 32'h0000_0100, 1'b0, 32'h8C22_0004, 32'h0000_0078};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 3, 32'h0000_0020, 1'b1, 32'h8C22_0004, 32'h0000_0078};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0024, 32'h1122_3344, 32'h5555_5555, 1, 32'h0000_0024, 1'b1, 32'h8C22_0004, 32'h0000_0078};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0031, 32'h0, 32'h0BAD_F00D, 0, 32'h0000_0030, 1'b0, 32'h8C22_0004, 32'h0BAD_F00D};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 32'h0000_7F00, 0, 32'h0000_0040, 1'b0, 32'h8C22_0004, 32'h0000_007F};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h80FF_FFFF, 2, 32'h0000_0040, 1'b0, 32'h8C22_0004, 32'hFFFF_FF80};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 32'h2402_FFFF, 0, 32'h0000_1000, 1'b0, 32'h2402_FFFF, 32'hFFFF_FF80};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    sampleCommon("rst");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
    end

    for (int i = 0; i < 60; i++) begin
      applyStimulus(makeRandomVec());
    end

    // Reset landing in the second BUSY cycle drops the access; a late ready must not capture.
    @(negedge clk);
    clearInputs();
    lord = 1'b1;
    adr  = 32'h0000_0200;
    #1;
    checkOutput("r5_req_stall", 32'(stall), 32'd1);
    @(negedge clk);
    lord = 1'b0;
    #1;
    checkOutput("r5_busy1_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("r5_busy2_stall", 32'(stall), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cur_instr = 32'h0;
    cur_data = 32'h0;
    cur_timeout = 1'b0;
    checkOutput("r5_req", 32'(mem_req), 32'd0);
    checkOutput("r5_we", 32'(mem_we), 32'd0);
    checkOutput("r5_addr", mem_addr, 32'h0);
    checkOutput("r5_stall", 32'(stall), 32'd0);
    sampleCommon("r5");
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    #1;
    checkOutput("r5_late_req", 32'(mem_req), 32'd0);
    checkOutput("r5_late_stall", 32'(stall), 32'd0);
    sampleCommon("r5_late");
    mem_ready = 1'b0;

    // Memory that never answers.
    @(negedge clk);
    irwrite = 1'b1;
    adr = 32'h0000_0300;
    #1;
    checkOutput("t6_req_stall", 32'(stall), 32'd1);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      irwrite = 1'b0;
      #1;
      checkOutput("t6_busy_req", 32'(mem_req), 32'd1);
      checkOutput("t6_busy_stall", 32'(stall), 32'd1);
      checkOutput("t6_busy_timeout", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    #1;
    checkOutput("t6_done_req", 32'(mem_req), 32'd0);
    checkOutput("t6_done_stall", 32'(stall), 32'd0);
    checkOutput("t6_done_timeout", 32'(timeout), 32'd1);
    checkOutput("t6_done_instr", instr, cur_instr);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_sticky_timeout", 32'(timeout), 32'd1);
    checkOutput("t6_idle_stall", 32'(stall), 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      irwrite = 1'b0;
      #1;
      checkOutput("t6_wait_stall", 32'(stall), 32'd1);
      checkOutput("t6_wait_req", 32'(mem_req), 32'd1);
      checkOutput("t6_wait_timeout", 32'(timeout), 32'd0);
    end
`endif
    @(negedge clk);
    clearInputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    cur_instr = 32'h0;
    cur_data = 32'h0;
    cur_timeout = 1'b0;
    checkOutput("end_rst_req", 32'(mem_req), 32'd0);
    checkOutput("end_rst_stall", 32'(stall), 32'd0);
    sampleCommon("end_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
